// File: rtl/uio_arb_pkg.sv
// Shared encodings for the uio pad-bus arbiter: FSM states, transfer direction, pad enable.
package uio_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_XFER = 2'd1;
  localparam arb_state_t ST_TURN = 2'd2;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [7:0] OE_ALL = 8'hFF;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester-side and pad-side bundle of the uio arbiter; master = requesters/pads, slave = arbiter.
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4
);
  // Handshake: a requester holds req[i] high for its whole burst; a byte moves in any
  // cycle where beat=1, and beat only rises for the requester whose grant bit is set.
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_dir;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   grant;
  logic              beat;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              busy;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;

  modport master (
    output req, req_dir, req_wdata, uio_in,
    input  grant, beat, rd_data, rd_valid, busy, uio_out, uio_oe
  );

  modport slave (
    input  req, req_dir, req_wdata, uio_in,
    output grant, beat, rd_data, rd_valid, busy, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  int j;

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_valid && i_req[j]) begin
        o_valid   = 1'b1;
        o_pick[j] = 1'b1;
        o_idx     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit uio pad bus: bounded bursts, latched direction, tri-state turnaround.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  uio_bus_arbiter_if.slave    bus,
  output arb_state_t          o_dbg_state
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_idx;
  logic [PW-1:0]   r_ptr;
  logic            r_dir;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tcnt;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;

  logic [NREQ-1:0] w_pick;
  logic [PW-1:0]   w_pidx;
  logic            w_pvalid;
  logic            w_in_xfer;
  logic            w_req_live;
  logic            w_beat;
  logic            w_last;
  logic            w_leave;
  logic [PW-1:0]   w_next_ptr;
  logic [7:0]      w_wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pidx),
    .o_valid (w_pvalid)
  );

  assign w_in_xfer  = (r_state == ST_XFER);
  assign w_req_live = |(r_grant & bus.req);
  assign w_beat     = w_in_xfer && w_req_live && ena;
  assign w_last     = w_beat && (r_cnt == CW'(MAX_BURST - 1));
  // Any mix of end conditions funnels into one TURN entry and one pointer step.
  assign w_leave    = !w_req_live || !ena || w_last;
  assign w_next_ptr = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_wdata = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_wdata = bus.req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_dir   <= DIR_IN;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ena && w_pvalid) begin
            r_state <= ST_XFER;
            r_grant <= w_pick;
            r_idx   <= w_pidx;
            r_dir   <= bus.req_dir[w_pidx];
            r_cnt   <= '0;
          end
        end
        ST_XFER: begin
          if (w_beat) r_cnt <= r_cnt + 1'b1;
          if (w_leave) begin
            r_state <= ST_TURN;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_tcnt  <= '0;
          end
        end
        ST_TURN: begin
          if (r_tcnt == TW'(TURN_CYC - 1)) r_state <= ST_IDLE;
          else                             r_tcnt  <= r_tcnt + 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_beat && (r_dir == DIR_IN);
      if (w_beat && (r_dir == DIR_IN)) r_rd_data <= bus.uio_in;
    end
  end

  // Pads are driven only while a write burst holds the bus; reset clears this without a clock.
  assign bus.uio_oe   = (w_in_xfer && r_dir == DIR_OUT) ? OE_ALL : 8'h00;
  assign bus.uio_out  = (w_in_xfer && r_dir == DIR_OUT) ? w_wdata : 8'h00;
  assign bus.grant    = r_grant;
  assign bus.beat     = w_beat;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NREQ=4, MAX_BURST=8, TURN_CYC=1).
module tb_uio_bus_arbiter;
  import uio_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  arb_state_t dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];

  uio_bus_arbiter_if #(.NREQ(4)) bus();

  uio_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURN_CYC(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(bus.grant)) begin errors++; $display("FAIL inv_onehot grant=%b", bus.grant); end
      checks++;
      if (bus.uio_oe !== 8'h00 && bus.uio_oe !== 8'hFF) begin errors++; $display("FAIL inv_oe_val oe=%h exp=00/FF", bus.uio_oe); end
      checks++;
      if (dbg_state != ST_XFER && bus.uio_oe !== 8'h00) begin errors++; $display("FAIL inv_oe_idle oe=%h exp=00 state=%0d", bus.uio_oe, dbg_state); end
    end
  end

  task automatic test_reset;
    rst = 1'b1; ena = 1'b0;
    bus.req = '0; bus.req_dir = '0; bus.req_wdata = '0; bus.uio_in = 8'h00;
    tick; tick;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.uio_oe !== 8'h00) begin errors++; $display("FAIL rst_oe got=%h exp=00", bus.uio_oe); end
    checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL rst_out got=%h exp=00", bus.uio_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL rst_beat got=%b exp=0", bus.beat); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd got=%b/%h exp=0/00", bus.rd_valid, bus.rd_data); end
    rst = 1'b0; ena = 1'b1;
    bus.req = 4'b0001; bus.req_dir = 4'b0001; bus.req_wdata = 32'h0000_0077;
    tick;
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rst_g0 got=%b exp=0001", bus.grant); end
    bus.req = 4'b0000;
    tick; tick;
    bus.req = 4'b0010; bus.req_dir = 4'b0010;
    tick;
    checks++; if (bus.grant !== 4'b0010 || bus.uio_oe !== 8'hFF) begin errors++; $display("FAIL rst_g1 got=%b/%h exp=0010/FF", bus.grant, bus.uio_oe); end
    rst = 1'b1;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_mid_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.uio_oe !== 8'h00) begin errors++; $display("FAIL rst_mid_oe got=%h exp=00", bus.uio_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    tick;
    rst = 1'b0; bus.req = 4'b1111;
    tick;
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rst_ptr got=%b exp=0001", bus.grant); end
    bus.req = 4'b0000;
    tick; tick;
  endtask

  task automatic test_write;
    ena = 1'b1;
    bus.req_dir = 4'b0010; bus.req_wdata = 32'h0000_A500; bus.req = 4'b0010;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL wr_pre_grant got=%b exp=0000", bus.grant); end
    tick;
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL wr_grant got=%b exp=0010", bus.grant); end
    checks++; if (bus.uio_out !== 8'hA5) begin errors++; $display("FAIL wr_out got=%h exp=A5", bus.uio_out); end
    for (int b = 0; b < 3; b++) begin
      if (b == 1) bus.req_dir = 4'b0000;
      if (b == 2) begin
        bus.req_wdata = 32'h0000_5A00;
        #1;
        checks++; if (bus.uio_out !== 8'h5A) begin errors++; $display("FAIL wr_live_wdata got=%h exp=5A", bus.uio_out); end
      end
      checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL wr_beat%0d got=%b exp=1", b, bus.beat); end
      checks++; if (bus.uio_oe !== 8'hFF) begin errors++; $display("FAIL wr_oe%0d got=%h exp=FF", b, bus.uio_oe); end
      tick;
    end
    bus.req = 4'b0000;
    #1;
    checks++; if (bus.beat !== 1'b0 || bus.grant !== 4'b0010) begin errors++; $display("FAIL wr_drop got=%b/%b exp=0/0010", bus.beat, bus.grant); end
    tick;
    checks++; if (bus.grant !== 4'b0000 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b1) begin errors++; $display("FAIL wr_turn got=%b/%h/%b exp=0000/00/1", bus.grant, bus.uio_oe, bus.busy); end
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_read;
    bus.req_dir = 4'b0000; bus.uio_in = 8'h3C; bus.req = 4'b0100;
    tick;
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL rd_grant got=%b exp=0100", bus.grant); end
    checks++; if (bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h00) begin errors++; $display("FAIL rd_pads got=%h/%h exp=00/00", bus.uio_oe, bus.uio_out); end
    checks++; if (bus.beat !== 1'b1 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_beat got=%b/%b exp=1/0", bus.beat, bus.rd_valid); end
    tick;
    bus.uio_in = 8'hFF; bus.req = 4'b0000;
    #1;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin errors++; $display("FAIL rd_data got=%b/%h exp=1/3C", bus.rd_valid, bus.rd_data); end
    checks++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL rd_drop got=%b exp=0", bus.beat); end
    tick;
    checks++; if (bus.rd_valid !== 1'b0 || bus.grant !== 4'b0000) begin errors++; $display("FAIL rd_turn got=%b/%b exp=0/0000", bus.rd_valid, bus.grant); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0]  g;
    logic [3:0]  dir;
    logic [31:0] wd;
    logic [7:0]  exp_oe;
    logic [7:0]  exp_out;
    int          idx;
    rst = 1'b1; tick; rst = 1'b0;
    ena = 1'b1;
    dir = 4'b0101; wd = 32'h4433_2211;
    bus.req_dir = dir; bus.req_wdata = wd;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    bus.req = 4'b1111;
    tick;
    for (int n = 0; n < 5; n++) begin
      g = exp_q.pop_front();
      idx = 0;
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      exp_oe  = dir[idx] ? 8'hFF : 8'h00;
      exp_out = dir[idx] ? wd[8*idx +: 8] : 8'h00;
      for (int b = 0; b < 8; b++) begin
        checks++; if (bus.grant !== g) begin errors++; $display("FAIL rr_grant n%0d b%0d got=%b exp=%b", n, b, bus.grant, g); end
        checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL rr_beat n%0d b%0d got=%b exp=1", n, b, bus.beat); end
        checks++; if (bus.uio_oe !== exp_oe || bus.uio_out !== exp_out) begin errors++; $display("FAIL rr_pads n%0d b%0d got=%h/%h exp=%h/%h", n, b, bus.uio_oe, bus.uio_out, exp_oe, exp_out); end
        tick;
      end
      checks++; if (bus.grant !== 4'b0000 || bus.beat !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rr_turn n%0d got=%b/%b/%b exp=0000/0/1", n, bus.grant, bus.beat, bus.busy); end
      if (n == 4) bus.req = 4'b0000;
      tick;
      checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rr_gap n%0d got=%b/%b exp=0000/0", n, bus.grant, bus.busy); end
      tick;
    end
  endtask

  task automatic test_ena;
    ena = 1'b0;
    bus.req = 4'b0001; bus.req_dir = 4'b0001; bus.req_wdata = 32'h0000_0099;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL ena_off c%0d got=%b/%b exp=0000/0", c, bus.grant, bus.busy); end
    end
    bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_wdata = 32'h0099_0000;
    ena = 1'b1;
    tick;
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL ena_grant got=%b exp=0100", bus.grant); end
    for (int b = 0; b < 3; b++) begin
      checks++; if (bus.beat !== 1'b1) begin errors++; $display("FAIL ena_beat%0d got=%b exp=1", b, bus.beat); end
      tick;
    end
    ena = 1'b0;
    #1;
    checks++; if (bus.beat !== 1'b0 || bus.grant !== 4'b0100) begin errors++; $display("FAIL ena_drop got=%b/%b exp=0/0100", bus.beat, bus.grant); end
    tick;
    checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b1 || bus.uio_oe !== 8'h00) begin errors++; $display("FAIL ena_turn got=%b/%b/%h exp=0000/1/00", bus.grant, bus.busy, bus.uio_oe); end
    tick;
    ena = 1'b1; bus.req = 4'b0101;
    tick;
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL ena_ptr got=%b exp=0001", bus.grant); end
    bus.req = 4'b0000;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_round_robin;
    test_ena;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
